// File: rtl/pc_sequencer_if.sv
`default_nettype none
// ============================================================================
// pc_sequencer_if : PC-update, fetch and execute handshake bundle
// Rev 1.0 : initial release
// ============================================================================
interface pc_sequencer_if;
  logic [31:0] pc_cur;
  logic        pc_ena;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        imem_ready;
  logic        exec_done;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp_valid;
  logic [31:0] jmp_target;
  logic        halt;
  logic        exc_req;
  logic        exc_taken;
  logic        halted;
  logic [31:0] retired;

  modport master (
    input  pc_cur, imem_ready, exec_done, br_taken, br_target,
           jmp_valid, jmp_target, halt, exc_req,
    output pc_ena, pc_next, imem_req, exc_taken, halted, retired
  );

  modport slave (
    output pc_cur, imem_ready, exec_done, br_taken, br_target,
           jmp_valid, jmp_target, halt, exc_req,
    input  pc_ena, pc_next, imem_req, exc_taken, halted, retired
  );
endinterface
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// pc_sequencer : fetch/execute sequencer owning the 32-bit PC update policy
// Rev 1.0 : initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0004
) (
  input wire             clk,
  input wire             rst,
  pc_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_EXEC   = 3'd2,
    S_UPDATE = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic        pc_ena_q, pc_ena_d;
  logic [31:0] pc_next_q, pc_next_d;
  logic        imem_req_q, imem_req_d;
  logic        exc_taken_q, exc_taken_d;
  logic        halted_q, halted_d;
  logic [31:0] retired_q, retired_d;
  logic        pend_q, pend_d;
  logic        first_q, first_d;

  logic [31:0] seq_pc;
  logic        jmp_bad;
  logic        br_bad;

  always_comb begin
    state_d     = state_q;
    pc_ena_d    = pc_ena_q;
    pc_next_d   = pc_next_q;
    imem_req_d  = imem_req_q;
    exc_taken_d = exc_taken_q;
    halted_d    = halted_q;
    retired_d   = retired_q;
    pend_d      = pend_q;
    first_d     = first_q;

    seq_pc  = bus.pc_cur + 32'd4;
    jmp_bad = |bus.jmp_target[1:0];
    br_bad  = |bus.br_target[1:0];

    if (state_q != S_HALT && bus.exc_req) begin
      pend_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        state_d    = S_FETCH;
        imem_req_d = 1'b1;
      end
      S_FETCH: begin
        if (bus.imem_ready) begin
          state_d    = S_EXEC;
          imem_req_d = 1'b0;
        end
      end
      S_EXEC: begin
        if (bus.exec_done) begin
          if (bus.halt) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
          end else begin
            state_d     = S_UPDATE;
            pc_ena_d    = 1'b1;
            exc_taken_d = 1'b0;
            // A request arriving alongside exec_done belongs to this instruction
            if (pend_q || bus.exc_req) begin
              pc_next_d   = EXC_VECTOR;
              exc_taken_d = 1'b1;
            end else if (first_q) begin
              pc_next_d = RESET_PC;
            end else if (bus.jmp_valid) begin
              pc_next_d   = jmp_bad ? EXC_VECTOR : bus.jmp_target;
              exc_taken_d = jmp_bad;
            end else if (bus.br_taken) begin
              pc_next_d   = br_bad ? EXC_VECTOR : bus.br_target;
              exc_taken_d = br_bad;
            end else begin
              pc_next_d = seq_pc;
            end
          end
        end
      end
      S_UPDATE: begin
        state_d     = S_FETCH;
        pc_ena_d    = 1'b0;
        exc_taken_d = 1'b0;
        imem_req_d  = 1'b1;
        retired_d   = retired_q + 32'd1;
        first_d     = 1'b0;
        // Consumed exception clears; a fresh request in this cycle stays pending
        if (exc_taken_q) begin
          pend_d = bus.exc_req;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_ena_q    <= 1'b0;
      pc_next_q   <= RESET_PC;
      imem_req_q  <= 1'b0;
      exc_taken_q <= 1'b0;
      halted_q    <= 1'b0;
      retired_q   <= 32'd0;
      pend_q      <= 1'b0;
      first_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      pc_ena_q    <= pc_ena_d;
      pc_next_q   <= pc_next_d;
      imem_req_q  <= imem_req_d;
      exc_taken_q <= exc_taken_d;
      halted_q    <= halted_d;
      retired_q   <= retired_d;
      pend_q      <= pend_d;
      first_q     <= first_d;
    end
  end

  assign bus.pc_ena    = pc_ena_q;
  assign bus.pc_next   = pc_next_q;
  assign bus.imem_req  = imem_req_q;
  assign bus.exc_taken = exc_taken_q;
  assign bus.halted    = halted_q;
  assign bus.retired   = retired_q;

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/execute sequencer that owns the update policy of the CPU's 32-bit program-counter register. It handshakes with instruction memory and the execute stage, and selects the next PC from sequential, branch, jump or exception sources. It drives the PC register's enable and data inputs, and reads back its current value. It also keeps a retired-instruction count for debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on the first update after reset (matches PC register reset value)
- EXC_VECTOR, 32'h0000_0004, PC loaded when an exception is taken

- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous and active-high
- pc_cur  in  32  current PC register output
- pc_ena  out  1  PC register load enable
- pc_next  out  32  PC register data input
- imem_req  out  1  instruction fetch request at address pc_cur
- imem_ready  in  1  fetch complete, instruction word valid this cycle
- exec_done  in  1  execute stage finished current instruction
- br_taken  in  1  conditional branch taken; sampled with exec_done
- br_target  in  32  branch target; sampled with exec_done
- jmp_valid  in  1  unconditional jump/jr; sampled with exec_done
- jmp_target  in  32  jump target; sampled with exec_done
- halt  in  1  current instruction is halt; sampled with exec_done
- exc_req  in  1  exception request, level or pulse, any cycle
- exc_taken  out  1  one-cycle pulse when PC is redirected to EXC_VECTOR
- halted  out  1  high in HALT state
- retired  out  32  count of completed PC updates, wraps modulo 2^32

## Operation
- States: IDLE, FETCH, EXEC, UPDATE, HALT. Registered state; all outputs registered or decoded from state only.
- IDLE: entered on reset. Goes to FETCH next cycle.
- FETCH: imem_req=1. Stays until imem_ready=1, then goes to EXEC.
- EXEC: waits for exec_done=1. On that cycle, latches the redirect request and targets, then goes to UPDATE. If halt=1 on that cycle, goes to HALT instead; no PC update and no retire increment.
- UPDATE: pc_ena=1 for exactly one cycle, then goes to FETCH. retired increments by 1.
- pc_next selection is computed when leaving EXEC, with priority:
  - 1: pending exception → EXC_VECTOR, exc_taken=1.
  - 2: jmp_valid → jmp_target.
  - 3: br_taken → br_target.
  - 4: otherwise pc_cur+4, 32-bit wrap (32'hFFFF_FFFC+4 → 0).
- Misaligned target: a selected jump or branch target with bits[1:0] ≠ 0 is treated as an exception. It loads EXC_VECTOR and asserts exc_taken.
- First update after reset: pc_next = RESET_PC regardless of inputs, unless an exception is pending.
- exc_req: sets a sticky pending flag in any state except HALT. The flag clears in the cycle UPDATE consumes it. The fetch or execute in flight is not aborted; the exception is applied at the next UPDATE.
- HALT: absorbing; only rst exits. exc_req is ignored in HALT.

## Timing
- Reset values: state=IDLE, pc_ena=0, pc_next=RESET_PC, imem_req=0, exc_taken=0, halted=0, retired=0, pending flag=0, first-update flag=1.
- rst asserted in any state takes effect on the next clock edge, including mid-fetch or in UPDATE. An UPDATE coincident with rst does not count.
- Minimum instruction period is 3 cycles (FETCH, EXEC, UPDATE) when imem_ready and exec_done are high on arrival.
- pc_ena and exc_taken are high only in UPDATE. pc_next is stable throughout UPDATE, and the PC register loads at the end of that cycle.
- imem_ready and exec_done are ignored outside FETCH and EXEC respectively.
- An exc_req arriving in the same cycle as exec_done is included in that instruction's UPDATE.

## Test plan
- Reset, then imem_ready=1 and exec_done=1 with no redirects → first pc_next=0, then 4, 8, 12 each 3 cycles apart; retired=3.
- Fetch stall: imem_ready delayed 5 cycles → imem_req held 5 cycles; pc_ena never asserts during FETCH.
- exec_done with jmp_valid=1 (0x100), br_taken=1 (0x200), pc_cur=0x40 → pc_next=0x100. Repeat with jmp_valid=0 → 0x200. Repeat with br_target=0x202 → pc_next=0x4 and exc_taken=1.
- exc_req pulsed one cycle during FETCH at pc_cur=0x80 → next UPDATE loads 0x4 with exc_taken=1; the following UPDATE yields 0x8.
- pc_cur=0xFFFF_FFFC with no redirect → pc_next=0; halt=1 with exec_done → halted=1, no further pc_ena, and exc_req is ignored.
- rst asserted in UPDATE → pc_ena=0 next cycle, retired=0, state IDLE, and the next update loads RESET_PC.
